// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage.
//   fetch_state_e    : redirect FSM states (RUN, FLUSH)
//   NOP              : instruction word injected into IF/ID on a redirect
//   DEFAULT_RESET_PC : default PC loaded by reset
package fetch_pkg;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } fetch_state_e;

  localparam logic [31:0] NOP              = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/branch_resolve.sv
// Combinational control-flow resolution for the instruction in WB.
// Inputs : wb_BranchZ, wb_BranchN, wb_Jump, wb_JumpMem - control-flow flags
//          wb_Z, wb_N                                  - ALU flags
//          wb_target                                   - register-sourced target
//          wb_data_mem_out                             - memory-sourced target
// Outputs: taken  - the WB instruction changes control flow
//          target - where fetch must go when taken
module branch_resolve (
  input  logic        wb_BranchZ,
  input  logic        wb_BranchN,
  input  logic        wb_Jump,
  input  logic        wb_JumpMem,
  input  logic        wb_Z,
  input  logic        wb_N,
  input  logic [31:0] wb_target,
  input  logic [31:0] wb_data_mem_out,
  output logic        taken,
  output logic [31:0] target
);

  assign taken  = wb_Jump | wb_JumpMem | (wb_BranchZ & wb_Z) | (wb_BranchN & wb_N);
  assign target = wb_JumpMem ? wb_data_mem_out : wb_target;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, IF/ID pipeline register and a small
// FSM that ignores WB redirects belonging to wrong-path instructions.
// Inputs : clk, rst (sync, active-high), stall (hold from ID),
//          wb_* control-flow flags, ALU flags and targets,
//          imem_data (instruction at imem_addr, same cycle)
// Outputs: imem_addr / pc_out (current PC, zero latency),
//          if_id_instr, if_id_pc, if_id_valid (IF/ID register),
//          squash (kill ID and EX in the redirect cycle)
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = DEFAULT_RESET_PC,
  parameter int unsigned FLUSH_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        wb_BranchZ,
  input  logic        wb_BranchN,
  input  logic        wb_Jump,
  input  logic        wb_JumpMem,
  input  logic        wb_Z,
  input  logic        wb_N,
  input  logic [31:0] wb_target,
  input  logic [31:0] wb_data_mem_out,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] pc_out,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc,
  output logic        if_id_valid,
  output logic        squash
);

  // Keep the counter at least one bit wide so FLUSH_DEPTH=0 still elaborates.
  localparam int unsigned CntW = (FLUSH_DEPTH > 0) ? $clog2(FLUSH_DEPTH + 1) : 1;

  logic         taken;
  logic [31:0]  target;
  logic         redirect;

  fetch_state_e state_q, state_d;
  logic [CntW-1:0] flush_cnt_q, flush_cnt_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  id_pc_q, id_pc_d;
  logic         valid_q, valid_d;

  branch_resolve u_branch_resolve (
    .wb_BranchZ      (wb_BranchZ),
    .wb_BranchN      (wb_BranchN),
    .wb_Jump         (wb_Jump),
    .wb_JumpMem      (wb_JumpMem),
    .wb_Z            (wb_Z),
    .wb_N            (wb_N),
    .wb_target       (wb_target),
    .wb_data_mem_out (wb_data_mem_out),
    .taken           (taken),
    .target          (target)
  );

  // In FLUSH the WB flags come from wrong-path instructions and are dropped.
  assign redirect = (state_q == RUN) && taken;

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    id_pc_d     = id_pc_q;
    valid_d     = valid_q;

    if (redirect) begin
      // Redirect wins over stall.
      pc_d    = target;
      instr_d = NOP;
      valid_d = 1'b0;
      if (FLUSH_DEPTH != 0) begin
        state_d     = FLUSH;
        flush_cnt_d = CntW'(FLUSH_DEPTH);
      end
    end else begin
      if (!stall) begin
        instr_d = imem_data;
        id_pc_d = pc_q;
        valid_d = 1'b1;
        pc_d    = pc_q + 32'd1;
      end
      // Counter runs every FLUSH cycle, stalled or not.
      if (state_q == FLUSH) begin
        flush_cnt_d = flush_cnt_q - CntW'(1);
        if (flush_cnt_q <= CntW'(1)) begin
          state_d = RUN;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      flush_cnt_q <= '0;
      pc_q        <= RESET_PC;
      instr_q     <= NOP;
      id_pc_q     <= 32'h0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      id_pc_q     <= id_pc_d;
      valid_q     <= valid_d;
    end
  end

  assign imem_addr   = pc_q;
  assign pc_out      = pc_q;
  assign if_id_instr = instr_q;
  assign if_id_pc    = id_pc_q;
  assign if_id_valid = valid_q;
  assign squash      = redirect & ~rst;

endmodule
